vend_ledger: RTL and testbench



---
 rtl/vend_pkg.sv | 42 ++++
 rtl/change_picker.sv | 29 ++
 rtl/vend_ledger.sv | 224 ++++++++++++++++++++++
 tb/tb_vend_ledger.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the vending transaction ledger.
//   bal_t        : 10-bit coin balance
//   COIN_*       : denomination codes as seen on coin_type / chg_coin
//   VAL_*        : coin-unit value of each denomination
//   DEF_*        : default prices and balance ceiling
//   state_t      : ledger FSM states
//   coin_value() : code -> value, invalid code (00) maps to 0
package vend_pkg;

   typedef logic [9:0] bal_t;

   localparam logic [1:0] COIN_NONE = 2'b00;
   localparam logic [1:0] COIN_1    = 2'b01;
   localparam logic [1:0] COIN_5    = 2'b10;
   localparam logic [1:0] COIN_10   = 2'b11;

   localparam bal_t VAL_1  = 10'd1;
   localparam bal_t VAL_5  = 10'd5;
   localparam bal_t VAL_10 = 10'd10;

   localparam int DEF_PRICE_ONE = 5;
   localparam int DEF_PRICE_TWO = 10;
   localparam int DEF_MAX_BAL   = 999;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACCEPT,
      ST_VEND,
      ST_CHANGE,
      ST_DONE
   } state_t;

   function automatic bal_t coin_value(input logic [1:0] code);
      case (code)
         COIN_1:  return VAL_1;
         COIN_5:  return VAL_5;
         COIN_10: return VAL_10;
         default: return '0;
      endcase
   endfunction

endpackage

// File: rtl/change_picker.sv
// Greedy change selection: largest denomination (10, 5, 1) not exceeding
// the balance. Purely combinational.
//   bal_i  : balance to be paid out
//   coin_o : denomination code, COIN_NONE when the balance is zero
//   val_o  : value of coin_o in coin units
module change_picker
   import vend_pkg::*;
(
   input  bal_t       bal_i,
   output logic [1:0] coin_o,
   output bal_t       val_o
);

   always_comb begin
      coin_o = COIN_NONE;
      val_o  = '0;
      if (bal_i >= VAL_10) begin
         coin_o = COIN_10;
         val_o  = VAL_10;
      end else if (bal_i >= VAL_5) begin
         coin_o = COIN_5;
         val_o  = VAL_5;
      end else if (bal_i != '0) begin
         coin_o = COIN_1;
         val_o  = VAL_1;
      end
   end

endmodule

// File: rtl/vend_ledger.sv
// Vending transaction ledger: coin accumulation, purchase accept/deny,
// item hand-off, and coin-by-coin change/refund payout.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no balance; first valid coin starts a transaction
// ST_ACCEPT | collecting coins; cancel > buy_two > buy_one > coin
// ST_VEND   | item request held until dispenser ack
// ST_CHANGE | paying out balance one coin per hopper handshake
// ST_DONE   | one cycle: raise get_ind, clear buy_flag, back to idle
//
// Ports:
//   clk, reset (async, active-low)
//   coin_in/coin_type        : coin insertion pulse and denomination
//   buy_one/buy_two          : purchase requests
//   cancel_req               : refund request
//   item_ack, chg_ready      : dispenser / hopper handshakes
//   coin_val                 : running balance
//   buy_flag                 : purchase in progress
//   cancle_flag, get_ind     : cancel-accepted / transaction-complete pulses
//   item_valid, item_id      : item request to dispenser
//   chg_valid, chg_coin      : change coin request to hopper
//   coin_reject, buy_deny    : refused-coin / insufficient-balance pulses
module vend_ledger
   import vend_pkg::*;
#(
   parameter int PRICE_ONE = DEF_PRICE_ONE,
   parameter int PRICE_TWO = DEF_PRICE_TWO,
   parameter int MAX_BAL   = DEF_MAX_BAL
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       coin_in,
   input  logic [1:0] coin_type,
   input  logic       buy_one,
   input  logic       buy_two,
   input  logic       cancel_req,
   input  logic       item_ack,
   input  logic       chg_ready,
   output logic [9:0] coin_val,
   output logic       buy_flag,
   output logic       cancle_flag,
   output logic       get_ind,
   output logic       item_valid,
   output logic       item_id,
   output logic       chg_valid,
   output logic [1:0] chg_coin,
   output logic       coin_reject,
   output logic       buy_deny
);

   localparam bal_t        PRICE_ONE_W = bal_t'(PRICE_ONE);
   localparam bal_t        PRICE_TWO_W = bal_t'(PRICE_TWO);
   localparam logic [10:0] MAX_BAL_W   = 11'(MAX_BAL);

   state_t     state_q, state_d;
   bal_t       coin_val_q, coin_val_d;
   logic       buy_flag_q, buy_flag_d;
   logic       cancle_flag_q, cancle_flag_d;
   logic       get_ind_q, get_ind_d;
   logic       item_valid_q, item_valid_d;
   logic       item_id_q, item_id_d;
   logic       chg_valid_q, chg_valid_d;
   logic [1:0] chg_coin_q, chg_coin_d;
   bal_t       chg_amt_q, chg_amt_d;
   logic       coin_reject_q, coin_reject_d;
   logic       buy_deny_q, buy_deny_d;

   logic        coin_ok;
   logic [10:0] coin_sum;
   logic        coin_fits;
   logic        take_coin;
   logic [1:0]  pick_coin;
   bal_t        pick_val;

   // Sum is one bit wider than the balance so the ceiling check cannot wrap.
   assign coin_ok   = coin_in && (coin_type != COIN_NONE);
   assign coin_sum  = {1'b0, coin_val_q} + {1'b0, coin_value(coin_type)};
   assign coin_fits = (coin_sum <= MAX_BAL_W);

   always_comb begin
      state_d       = state_q;
      coin_val_d    = coin_val_q;
      buy_flag_d    = buy_flag_q;
      item_valid_d  = item_valid_q;
      item_id_d     = item_id_q;
      cancle_flag_d = 1'b0;
      get_ind_d     = 1'b0;
      coin_reject_d = 1'b0;
      buy_deny_d    = 1'b0;
      take_coin     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            buy_deny_d = buy_one | buy_two;
            take_coin  = 1'b1;
         end
         ST_ACCEPT: begin
            if (cancel_req) begin
               cancle_flag_d = 1'b1;
               coin_reject_d = coin_ok;
               state_d       = ST_CHANGE;
            end else if (buy_two && (coin_val_q >= PRICE_TWO_W)) begin
               coin_val_d    = coin_val_q - PRICE_TWO_W;
               buy_flag_d    = 1'b1;
               item_valid_d  = 1'b1;
               item_id_d     = 1'b1;
               coin_reject_d = coin_ok;
               state_d       = ST_VEND;
            end else if (buy_two) begin
               // A denied buy_two masks buy_one but still lets a coin in.
               buy_deny_d = 1'b1;
               take_coin  = 1'b1;
            end else if (buy_one && (coin_val_q >= PRICE_ONE_W)) begin
               coin_val_d    = coin_val_q - PRICE_ONE_W;
               buy_flag_d    = 1'b1;
               item_valid_d  = 1'b1;
               item_id_d     = 1'b0;
               coin_reject_d = coin_ok;
               state_d       = ST_VEND;
            end else if (buy_one) begin
               buy_deny_d = 1'b1;
               take_coin  = 1'b1;
            end else begin
               take_coin = 1'b1;
            end
         end
         ST_VEND: begin
            coin_reject_d = coin_ok;
            if (item_ack) begin
               item_valid_d = 1'b0;
               state_d      = (coin_val_q != '0) ? ST_CHANGE : ST_DONE;
            end
         end
         ST_CHANGE: begin
            coin_reject_d = coin_ok;
            if (coin_val_q == '0) begin
               state_d = ST_DONE;
            end else if (chg_valid_q && chg_ready) begin
               coin_val_d = coin_val_q - chg_amt_q;
               if (coin_val_q == chg_amt_q) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            coin_reject_d = coin_ok;
            get_ind_d     = 1'b1;
            buy_flag_d    = 1'b0;
            state_d       = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (take_coin && coin_ok) begin
         if (coin_fits) begin
            coin_val_d = coin_sum[9:0];
            if (state_q == ST_IDLE) begin
               state_d = ST_ACCEPT;
            end
         end else begin
            coin_reject_d = 1'b1;
         end
      end
   end

   // Change request is registered from the next balance, so the coin offered
   // tracks the balance after each handshake and holds still during a stall.
   change_picker u_picker (
      .bal_i  (coin_val_d),
      .coin_o (pick_coin),
      .val_o  (pick_val)
   );

   always_comb begin
      chg_valid_d = (state_d == ST_CHANGE) && (coin_val_d != '0);
      chg_coin_d  = chg_valid_d ? pick_coin : COIN_NONE;
      chg_amt_d   = chg_valid_d ? pick_val : '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         coin_val_q    <= '0;
         buy_flag_q    <= 1'b0;
         cancle_flag_q <= 1'b0;
         get_ind_q     <= 1'b0;
         item_valid_q  <= 1'b0;
         item_id_q     <= 1'b0;
         chg_valid_q   <= 1'b0;
         chg_coin_q    <= COIN_NONE;
         chg_amt_q     <= '0;
         coin_reject_q <= 1'b0;
         buy_deny_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         coin_val_q    <= coin_val_d;
         buy_flag_q    <= buy_flag_d;
         cancle_flag_q <= cancle_flag_d;
         get_ind_q     <= get_ind_d;
         item_valid_q  <= item_valid_d;
         item_id_q     <= item_id_d;
         chg_valid_q   <= chg_valid_d;
         chg_coin_q    <= chg_coin_d;
         chg_amt_q     <= chg_amt_d;
         coin_reject_q <= coin_reject_d;
         buy_deny_q    <= buy_deny_d;
      end
   end

   assign coin_val    = coin_val_q;
   assign buy_flag    = buy_flag_q;
   assign cancle_flag = cancle_flag_q;
   assign get_ind     = get_ind_q;
   assign item_valid  = item_valid_q;
   assign item_id     = item_id_q;
   assign chg_valid   = chg_valid_q;
   assign chg_coin    = chg_coin_q;
   assign coin_reject = coin_reject_q;
   assign buy_deny    = buy_deny_q;

endmodule

// File: tb/tb_vend_ledger.sv
// Directed bench for vend_ledger: a default-parameter instance plus a
// MAX_BAL=20 instance sharing the same stimulus for the ceiling case.
module tb_vend_ledger;

   logic       clk;
   logic       reset;
   logic       coin_in;
   logic [1:0] coin_type;
   logic       buy_one;
   logic       buy_two;
   logic       cancel_req;
   logic       item_ack;
   logic       chg_ready;

   logic [9:0] coin_val;
   logic       buy_flag, cancle_flag, get_ind, item_valid, item_id;
   logic       chg_valid, coin_reject, buy_deny;
   logic [1:0] chg_coin;

   logic [9:0] coin_val_b;
   logic       buy_flag_b, cancle_flag_b, get_ind_b, item_valid_b, item_id_b;
   logic       chg_valid_b, coin_reject_b, buy_deny_b;
   logic [1:0] chg_coin_b;

   int total = 0;
   int bad   = 0;

   vend_ledger u_dut (
      .clk         (clk),
      .reset       (reset),
      .coin_in     (coin_in),
      .coin_type   (coin_type),
      .buy_one     (buy_one),
      .buy_two     (buy_two),
      .cancel_req  (cancel_req),
      .item_ack    (item_ack),
      .chg_ready   (chg_ready),
      .coin_val    (coin_val),
      .buy_flag    (buy_flag),
      .cancle_flag (cancle_flag),
      .get_ind     (get_ind),
      .item_valid  (item_valid),
      .item_id     (item_id),
      .chg_valid   (chg_valid),
      .chg_coin    (chg_coin),
      .coin_reject (coin_reject),
      .buy_deny    (buy_deny)
   );

   vend_ledger #(.MAX_BAL(20)) u_dut20 (
      .clk         (clk),
      .reset       (reset),
      .coin_in     (coin_in),
      .coin_type   (coin_type),
      .buy_one     (buy_one),
      .buy_two     (buy_two),
      .cancel_req  (cancel_req),
      .item_ack    (item_ack),
      .chg_ready   (chg_ready),
      .coin_val    (coin_val_b),
      .buy_flag    (buy_flag_b),
      .cancle_flag (cancle_flag_b),
      .get_ind     (get_ind_b),
      .item_valid  (item_valid_b),
      .item_id     (item_id_b),
      .chg_valid   (chg_valid_b),
      .chg_coin    (chg_coin_b),
      .coin_reject (coin_reject_b),
      .buy_deny    (buy_deny_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic coin(input logic [1:0] t);
      coin_in   = 1'b1;
      coin_type = t;
      tick();
      coin_in   = 1'b0;
      coin_type = 2'b00;
   endtask

   function automatic logic [9:0] outs_a();
      return {buy_flag, cancle_flag, get_ind, item_valid, item_id,
              chg_valid, chg_coin, coin_reject, buy_deny};
   endfunction

   function automatic logic [9:0] outs_b();
      return {buy_flag_b, cancle_flag_b, get_ind_b, item_valid_b, item_id_b,
              chg_valid_b, chg_coin_b, coin_reject_b, buy_deny_b};
   endfunction

   initial begin
      reset = 1'b0; coin_in = 1'b0; coin_type = 2'b00;
      buy_one = 1'b0; buy_two = 1'b0; cancel_req = 1'b0;
      item_ack = 1'b0; chg_ready = 1'b0;
      tick(); tick();
      chk("rst_outs", 32'(outs_a()), 0);
      chk("rst_bal", 32'(coin_val), 0);
      reset = 1'b1;
      tick();

      // buy while idle is denied
      buy_two = 1'b1; tick(); buy_two = 1'b0;
      chk("idle_deny", 32'(buy_deny), 1);
      chk("idle_deny_bal", 32'(coin_val), 0);
      tick();
      chk("idle_deny_pulse", 32'(buy_deny), 0);

      // 5 + 1, buy product one, one coin of change
      coin(2'b10);
      chk("t1_bal5", 32'(coin_val), 5);
      coin(2'b01);
      chk("t1_bal6", 32'(coin_val), 6);
      buy_one = 1'b1; tick(); buy_one = 1'b0;
      chk("t1_ivalid", 32'(item_valid), 1);
      chk("t1_iid", 32'(item_id), 0);
      chk("t1_bal1", 32'(coin_val), 1);
      chk("t1_bflag", 32'(buy_flag), 1);
      item_ack = 1'b1; tick(); item_ack = 1'b0;
      chk("t1_ivalid_off", 32'(item_valid), 0);
      chk("t1_cvalid", 32'(chg_valid), 1);
      chk("t1_ccoin", 32'(chg_coin), 1);
      chg_ready = 1'b1; tick(); chg_ready = 1'b0;
      chk("t1_bal0", 32'(coin_val), 0);
      chk("t1_cvalid_off", 32'(chg_valid), 0);
      chk("t1_get_early", 32'(get_ind), 0);
      tick();
      chk("t1_get", 32'(get_ind), 1);
      chk("t1_bflag_off", 32'(buy_flag), 0);
      tick();
      chk("t1_get_pulse", 32'(get_ind), 0);

      // 1 + 1, denied buy_two, cancel with two 1-coin refunds
      coin(2'b01); coin(2'b01);
      chk("t2_bal2", 32'(coin_val), 2);
      buy_two = 1'b1; tick(); buy_two = 1'b0;
      chk("t2_deny", 32'(buy_deny), 1);
      chk("t2_deny_bal", 32'(coin_val), 2);
      cancel_req = 1'b1; tick(); cancel_req = 1'b0;
      chk("t2_cancel", 32'(cancle_flag), 1);
      chk("t2_bflag", 32'(buy_flag), 0);
      chk("t2_ccoin_a", 32'(chg_coin), 1);
      tick();
      chk("t2_cancel_pulse", 32'(cancle_flag), 0);
      chg_ready = 1'b1; tick();
      chk("t2_bal1", 32'(coin_val), 1);
      chk("t2_ccoin_b", 32'(chg_coin), 1);
      tick(); chg_ready = 1'b0;
      chk("t2_bal0", 32'(coin_val), 0);
      chk("t2_cvalid_off", 32'(chg_valid), 0);
      tick();
      chk("t2_get", 32'(get_ind), 1);
      tick();

      // 10+10+5+1, buy_two, change 10/5/1 with a 3-cycle stall
      coin(2'b11); coin(2'b11); coin(2'b10); coin(2'b01);
      chk("t3_bal26", 32'(coin_val), 26);
      buy_two = 1'b1; tick(); buy_two = 1'b0;
      chk("t3_bal16", 32'(coin_val), 16);
      chk("t3_iid", 32'(item_id), 1);
      tick();
      chk("t3_ivalid_hold", 32'(item_valid), 1);
      item_ack = 1'b1; tick(); item_ack = 1'b0;
      chk("t3_ccoin10", 32'(chg_coin), 3);
      tick();
      chk("t3_stall1", 32'(chg_coin), 3);
      coin(2'b01);
      chk("t3_reject", 32'(coin_reject), 1);
      chk("t3_reject_bal", 32'(coin_val), 16);
      chk("t3_stall2", 32'(chg_coin), 3);
      tick();
      chk("t3_reject_pulse", 32'(coin_reject), 0);
      chk("t3_stall3", 32'(chg_coin), 3);
      chg_ready = 1'b1; tick();
      chk("t3_bal6", 32'(coin_val), 6);
      chk("t3_ccoin5", 32'(chg_coin), 2);
      tick();
      chk("t3_bal1", 32'(coin_val), 1);
      chk("t3_ccoin1", 32'(chg_coin), 1);
      tick(); chg_ready = 1'b0;
      chk("t3_bal0", 32'(coin_val), 0);
      chk("t3_cvalid_off", 32'(chg_valid), 0);
      tick();
      chk("t3_get", 32'(get_ind), 1);
      tick();

      // exact price, no change: ack -> DONE -> get_ind
      coin(2'b11);
      buy_two = 1'b1; tick(); buy_two = 1'b0;
      chk("t4_bal0", 32'(coin_val), 0);
      chk("t4_ivalid", 32'(item_valid), 1);
      item_ack = 1'b1; tick(); item_ack = 1'b0;
      chk("t4_ivalid_off", 32'(item_valid), 0);
      chk("t4_cvalid", 32'(chg_valid), 0);
      chk("t4_get_early", 32'(get_ind), 0);
      tick();
      chk("t4_get", 32'(get_ind), 1);
      chk("t4_bflag_off", 32'(buy_flag), 0);
      tick();

      // both buys at balance 6: buy_two denied, buy_one not tried
      coin(2'b10); coin(2'b01);
      buy_one = 1'b1; buy_two = 1'b1; tick(); buy_one = 1'b0; buy_two = 1'b0;
      chk("t5_deny", 32'(buy_deny), 1);
      chk("t5_no_item", 32'(item_valid), 0);
      chk("t5_bal6", 32'(coin_val), 6);
      buy_two = 1'b1; coin(2'b01); buy_two = 1'b0;
      chk("t5_deny_coin", 32'(buy_deny), 1);
      chk("t5_bal7", 32'(coin_val), 7);
      chk("t5_no_reject", 32'(coin_reject), 0);
      cancel_req = 1'b1; tick(); cancel_req = 1'b0;
      chk("t5_ccoin5", 32'(chg_coin), 2);
      chg_ready = 1'b1; tick(); tick(); tick(); chg_ready = 1'b0;
      chk("t5_bal0", 32'(coin_val), 0);
      tick();
      chk("t5_get", 32'(get_ind), 1);
      tick();

      // cancel + buy_two + coin together at balance 12
      coin(2'b11); coin(2'b01); coin(2'b01);
      chk("t6_bal12", 32'(coin_val), 12);
      cancel_req = 1'b1; buy_two = 1'b1; coin(2'b11);
      cancel_req = 1'b0; buy_two = 1'b0;
      chk("t6_cancel", 32'(cancle_flag), 1);
      chk("t6_reject", 32'(coin_reject), 1);
      chk("t6_no_item", 32'(item_valid), 0);
      chk("t6_bal12_kept", 32'(coin_val), 12);
      chk("t6_ccoin10", 32'(chg_coin), 3);
      chg_ready = 1'b1; tick();
      chk("t6_bal2", 32'(coin_val), 2);
      chk("t6_ccoin1a", 32'(chg_coin), 1);
      tick();
      chk("t6_bal1", 32'(coin_val), 1);
      tick(); chg_ready = 1'b0;
      chk("t6_bal0", 32'(coin_val), 0);
      tick();
      chk("t6_get", 32'(get_ind), 1);
      tick();

      // async reset in the middle of a refund
      coin(2'b11);
      cancel_req = 1'b1; tick(); cancel_req = 1'b0;
      chk("t7_cvalid", 32'(chg_valid), 1);
      #2;
      reset = 1'b0;
      #1;
      chk("t7_rst_outs", 32'(outs_a()), 0);
      chk("t7_rst_bal", 32'(coin_val), 0);
      chk("t7_rst_outs_b", 32'(outs_b()), 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      coin(2'b11);
      chk("t7_first_coin", 32'(coin_val), 10);

      // ceiling on the MAX_BAL=20 instance
      coin(2'b11);
      chk("t8_bal20", 32'(coin_val_b), 20);
      chk("t8_at_max_ok", 32'(coin_reject_b), 0);
      coin(2'b01);
      chk("t8_reject", 32'(coin_reject_b), 1);
      chk("t8_bal_kept", 32'(coin_val_b), 20);
      chk("t8_default_bal21", 32'(coin_val), 21);
      tick();
      chk("t8_reject_pulse", 32'(coin_reject_b), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
